// File: rtl/tx_stripe_serializer_if.sv
// Byte-stream handshake between the upstream byte mux and tx_stripe_serializer.
// master drives bytes in, slave (the serializer) returns in_ready.
interface tx_stripe_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tx_stripe_serializer.sv
// Stripes an incoming byte stream across x1/x2/x4/x8 lanes and serializes each lane LSB-first.
// Optional periodic skip-symbol insertion is enabled by defining TX_SKP_INSERT_EN.
module tx_stripe_serializer #(
    parameter int unsigned LANES        = 4,
    parameter logic [7:0]  IDLE_SYM     = 8'h7C,
    parameter logic [7:0]  SKP_SYM      = 8'h1C,
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enb,
    input  logic [1:0]           width_sel,
    tx_stripe_serializer_if.slave up,
    output logic [LANES-1:0]     lane_out,
    output logic [LANES-1:0]     active_mask,
    output logic                 sym_start
);

    localparam int unsigned MaxCode  = (LANES >= 8) ? 3 : (LANES >= 4) ? 2 : (LANES >= 2) ? 1 : 0;
    localparam logic [1:0]  MaxCodeL = 2'(MaxCode);

    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       wcode_q, wcode_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [7:0]       slot_q [LANES];
    logic [7:0]       slot_d [LANES];
    logic [7:0]       sh_q [LANES];
    logic [7:0]       sh_d [LANES];
    logic             sym_q, sym_d;

    logic       boundary, full, drain, skip, ready, accept;
    logic [3:0] n_cur, wr_idx;
    logic [1:0] wsel_clamp;

    function automatic logic [LANES-1:0] code_mask(input logic [1:0] code);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < (1 << code));
        end
        return m;
    endfunction

`ifdef TX_SKP_INSERT_EN
    localparam int unsigned     SkpW    = $clog2(SKP_INTERVAL);
    localparam logic [SkpW-1:0] SkpLast = SkpW'(SKP_INTERVAL - 1);

    logic [SkpW-1:0] skp_q, skp_d;

    always_comb begin
        skip  = boundary && enb && (skp_q == SkpLast);
        skp_d = skp_q;
        if (boundary && enb) begin
            skp_d = skip ? '0 : skp_q + SkpW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skp_q <= '0;
        end else begin
            skp_q <= skp_d;
        end
    end
`else
    logic unused_skp;
    assign unused_skp = ^{SKP_SYM, SKP_INTERVAL};
    assign skip       = 1'b0;
`endif

    always_comb begin
        n_cur      = 4'd1 << wcode_q;
        boundary   = (cnt_q == 3'd7);
        full       = (ptr_q == n_cur);
        drain      = boundary && enb && full && !skip;
        ready      = reset && enb && ((ptr_q < n_cur) || drain);
        accept     = up.in_valid && ready;
        wsel_clamp = (width_sel > MaxCodeL) ? MaxCodeL : width_sel;
    end

    always_comb begin
        cnt_d   = cnt_q + 3'd1;
        sym_d   = boundary;
        wcode_d = wcode_q;
        // Width only changes when nothing is staged, so a group never straddles two widths.
        if (boundary && (ptr_q == 4'd0)) begin
            wcode_d = wsel_clamp;
        end
        mask_d = boundary ? code_mask(wcode_d) : mask_q;

        ptr_d  = ptr_q;
        slot_d = slot_q;
        wr_idx = drain ? 4'd0 : ptr_q;
        if (drain) begin
            ptr_d = 4'd0;
        end
        if (accept) begin
            ptr_d = wr_idx + 4'd1;
            for (int i = 0; i < LANES; i++) begin
                if (wr_idx == 4'(i)) begin
                    slot_d[i] = up.in_data;
                end
            end
        end

        for (int i = 0; i < LANES; i++) begin
            if (!boundary) begin
                sh_d[i] = {1'b0, sh_q[i][7:1]};
            end else if (!enb || !mask_d[i]) begin
                sh_d[i] = 8'h00;
            end else if (skip) begin
                sh_d[i] = SKP_SYM;
            end else if (drain) begin
                sh_d[i] = slot_q[i];
            end else begin
                sh_d[i] = IDLE_SYM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            wcode_q <= '0;
            mask_q  <= LANES'(1);
            ptr_q   <= '0;
            sym_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                slot_q[i] <= '0;
                sh_q[i]   <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            wcode_q <= wcode_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            sym_q   <= sym_d;
            slot_q  <= slot_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_out[i] = sh_q[i][0];
        end
    end

    assign active_mask = mask_q;
    assign sym_start   = sym_q;
    assign up.in_ready = ready;

endmodule

// File: doc/tx_stripe_serializer.md
Name: tx_stripe_serializer

Overview:
- Parametrised PCIe-style transmit lane engine.
- Accepts a byte stream over a valid/ready handshake and stripes consecutive bytes across a run-time-selectable number of active lanes (x1/x2/x4/x8, capped at LANES).
- Serializes each lane's byte LSB-first, one bit per clk; idle symbols are sent whenever no complete byte group is available.
- Sits between the upstream byte mux/control logic and the physical lane outputs. Replaces the fixed 4-lane striping plus per-lane serializer chain with a single-clock block.

Parameters:
- LANES, 4, number of physical lanes; legal values 1, 2, 4, 8.
- IDLE_SYM, 8'h7C, symbol sent on active lanes when no complete group is staged.
- SKP_SYM, 8'h1C, skip symbol (used only with the optional feature).
- SKP_INTERVAL, 16, symbol periods between skip symbols (optional feature); legal range >= 2.

Ports:
- clk  input  1  single clock; bit rate of every lane.
- reset  input  1  asynchronous, active-low reset.
- enb  input  1  block enable, sampled at symbol boundaries and for handshake.
- width_sel  input  2  requested link width: 00 x1, 01 x2, 10 x4, 11 x8; clamped to LANES.
- in_data  input  8  byte from upstream.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  byte accepted on a cycle where in_valid && in_ready.
- lane_out  output  LANES  serial bit per lane; lane 0 is the LSB.
- active_mask  output  LANES  one bit per currently active lane.
- sym_start  output  1  high on the cycle bit 0 of a new symbol is driven.

Behaviour:
- Reset values (reset=0): lane_out=0, in_ready=0, sym_start=0, active_mask=1 (x1), bit counter=0, staging empty, shift registers=0, skip counter=0.
- Symbol period is 8 clk. A 3-bit bit counter increments every cycle and wraps from 7 to 0.
- The boundary is the cycle with counter==7. On that edge every lane shift register loads its next symbol.
- On the cycle after a load: sym_start=1 and lane_out[i]=bit 0 of lane i. Bits 1..7 follow on the next 7 cycles.
- Active lane count N = min(2^width_sel, LANES).
  - width_sel is applied only at a boundary where staging is empty; otherwise the change is deferred to the first such boundary.
  - active_mask updates on the same edge as the load.
- Staging buffer: N byte slots plus a write pointer.
  - Accepted bytes fill slot 0, 1, ... N-1 in order; byte k goes to lane k.
  - in_ready = enb && (pointer < N), or the buffer is being drained this cycle.
  - Same-cycle drain-and-accept: if the buffer is full and drains at the boundary while in_valid is high, in_ready=1 and the byte lands in slot 0 of the emptied buffer.
- Load selection at each boundary:
  - enb=0: load 0 on all lanes; staging is retained.
  - Else if staging is full: load slot i into lane i for i<N, then clear the pointer.
  - Else: load IDLE_SYM on all active lanes. A partial group stays staged, is never padded, and is never split.
- Inactive lanes always load 0.
- Latency: the first bit of a group appears on the cycle after the first boundary at which that group is complete.
- Full throughput: x8 sustains 1 byte/clk; xN sustains N bytes per 8 clk.
- enb=0 mid-symbol: in_ready drops immediately. The current symbol completes; the next load is 0.
- Reset mid-symbol forces all reset values asynchronously. A partially shifted symbol is discarded.

Optional Feature:
- Macro: TX_SKP_INSERT_EN.
- Defined:
  - A symbol-period counter increments at every boundary where enb=1.
  - At the boundary where it equals SKP_INTERVAL-1, all active lanes load SKP_SYM instead of data or idle, and the counter clears.
  - Staging is retained and in_ready still follows the fill rule.
  - A complete group is delayed by exactly one symbol period.
- Undefined: no counter, no SKP_SYM is ever emitted, and the SKP_SYM and SKP_INTERVAL parameters are ignored.

Test Plan:
- Reset then idle, LANES=4, width_sel=10, enb=1, in_valid=0:
  - cycles 0-7 lane_out=0.
  - From cycle 8, lanes 0-3 repeat 0,0,1,1,1,1,1,0 (0x7C LSB-first).
  - sym_start pulses every 8 clk.
- x4 stripe: send bytes 0xA5, 0x3C, 0xFF, 0x01 back-to-back:
  - the next symbol carries lane0=0xA5, lane1=0x3C, lane2=0xFF, lane3=0x01.
  - in_ready=0 after the 4th byte until the boundary.
- Partial group: x2 with a single byte 0x55, then no more input:
  - lanes send 0x7C repeatedly; 0x55 is held.
  - Supplying 0x66 later yields lane0=0x55, lane1=0x66 in the next symbol.
- Width change: staging half-full at x4, set width_sel=00:
  - active_mask stays 4'b1111 until the group drains, then becomes 4'b0001.
  - Lanes 1-3 output 0 afterwards.
- enb low mid-symbol at bit 3:
  - current symbol finishes; next symbol is all 0; in_ready=0 within 1 clk.
  - Re-assert enb: idle resumes at the next boundary.
- With TX_SKP_INSERT_EN, SKP_INTERVAL=4, continuous x1 input:
  - every 4th symbol is 0x1C.
  - No byte is dropped or reordered (compare 64-byte sequence).
